xbox_mem_rr_arb: RTL

Round-robin arbiter that shares one XBOX accelerator memory instance port between up to four requesters, e.g. the matmul datapath and a load/store DMA engine. Each requester sees a valid/ready command channel and a one-cycle-latency read-response channel. The arbiter drives the memory's addr/wdata/be/rd/wr pins and returns read data tagged to the issuer. Burst locking keeps multi-beat sequences atomic, and a watchdog releases locks held by stalled owners.

---
 rtl/xbox_arb_pkg.sv | 16 +
 rtl/xbox_rr_pick.sv | 38 +++
 rtl/xbox_mem_rr_arb.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/xbox_arb_pkg.sv
// rtl/xbox_arb_pkg.sv - shared types and constants for the XBOX memory port arbiter
package xbox_arb_pkg;

    // Arbiter FSM: either nobody owns the port or one requester holds it for a burst
    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Width of the idle-cycle watchdog that guards a held lock
    localparam int WDOG_W = 8;

    // One memory line: eight 32-bit words
    typedef logic [7:0][31:0] xbox_line_t;

endpackage

// File: rtl/xbox_rr_pick.sv
// rtl/xbox_rr_pick.sv - rotating priority encoder, search starts at ptr and wraps
module xbox_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o
);

    // One extra bit so ptr+k can be wrapped modulo a non-power-of-two count
    localparam int             CW  = IDX_W + 1;
    localparam logic [CW-1:0]  NUM = CW'(NUM_REQ);

    logic [CW-1:0] cand;
    logic          found;

    // Walk the requesters from ptr upward and grant the first one that is valid
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_i} + CW'(k);
            if (cand >= NUM) begin
                cand = cand - NUM;
            end
            if (!found && valid_i[cand[IDX_W-1:0]]) begin
                found                     = 1'b1;
                grant_o[cand[IDX_W-1:0]]  = 1'b1;
                idx_o                     = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/xbox_mem_rr_arb.sv
// rtl/xbox_mem_rr_arb.sv - round-robin arbiter with burst lock sharing one XBOX memory port
module xbox_mem_rr_arb
    import xbox_arb_pkg::*;
#(
    parameter int LOG2_LINES_PER_MEM = 8,
    parameter int NUM_REQ            = 2,
    parameter int LOCK_TIMEOUT       = 16
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [NUM_REQ-1:0]                            req_valid_i,
    input  logic [NUM_REQ-1:0]                            req_wr_i,
    input  logic [NUM_REQ-1:0]                            req_last_i,
    input  logic [NUM_REQ-1:0][LOG2_LINES_PER_MEM-1:0]    req_addr_i,
    input  xbox_line_t [NUM_REQ-1:0]                      req_wdata_i,
    input  logic [NUM_REQ-1:0][31:0]                      req_be_i,
    output logic [NUM_REQ-1:0]                            req_ready_o,
    output logic [NUM_REQ-1:0]                            rsp_valid_o,
    output xbox_line_t                                    rsp_rdata_o,
    output logic [LOG2_LINES_PER_MEM-1:0]                 mem_addr_o,
    output xbox_line_t                                    mem_wdata_o,
    output logic [31:0]                                   mem_be_o,
    output logic                                          mem_rd_o,
    output logic                                          mem_wr_o,
    input  xbox_line_t                                    mem_rdata_i,
    output logic                                          lock_err_o
);

    localparam int                IDX_W      = (NUM_REQ > 2) ? 2 : 1;
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(LOCK_TIMEOUT);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_REQ - 1);

    arb_state_t                    state_q, state_d;
    logic [IDX_W-1:0]              owner_q, owner_d;
    logic [IDX_W-1:0]              ptr_q, ptr_d;
    logic [WDOG_W-1:0]             wdog_q, wdog_d;
    logic [NUM_REQ-1:0]            rsp_valid_q, rsp_valid_d;
    logic                          lock_err_q, lock_err_d;
    logic [LOG2_LINES_PER_MEM-1:0] addr_q, addr_d;
    xbox_line_t                    wdata_q, wdata_d;

    logic [NUM_REQ-1:0]            pick_grant;
    logic [IDX_W-1:0]              pick_idx;
    logic [NUM_REQ-1:0]            grant;
    logic [IDX_W-1:0]              gidx;
    logic                          accept;
    logic                          sel_wr;
    logic                          sel_last;

    xbox_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .valid_i (req_valid_i),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx)
    );

    // Grant: round-robin pick when free, only the owner while a burst holds the port
    always_comb begin
        grant = '0;
        gidx  = owner_q;
        if (state_q == ARB_IDLE) begin
            grant = pick_grant;
            gidx  = pick_idx;
        end else begin
            grant[owner_q] = req_valid_i[owner_q];
        end
        accept   = |grant;
        sel_wr   = req_wr_i[gidx];
        sel_last = req_last_i[gidx];
    end

    // Memory command: forward the granted beat; addr/wdata hold their last value when idle
    always_comb begin
        addr_d      = accept ? req_addr_i[gidx] : addr_q;
        wdata_d     = accept ? req_wdata_i[gidx] : wdata_q;
        mem_addr_o  = addr_d;
        mem_wdata_o = wdata_d;
        mem_be_o    = accept ? req_be_i[gidx] : 32'h0;
        mem_rd_o    = accept & ~sel_wr;
        mem_wr_o    = accept & sel_wr;
        rsp_valid_d = (accept && !sel_wr) ? grant : '0;
    end

    // Lock, pointer and watchdog bookkeeping; an owner beat always beats the timeout
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        wdog_d     = wdog_q;
        lock_err_d = lock_err_q;
        if (accept) begin
            ptr_d  = (gidx == LAST_IDX) ? '0 : gidx + 1'b1;
            wdog_d = '0;
            if (sel_last) begin
                state_d = ARB_IDLE;
            end else begin
                state_d = ARB_LOCKED;
                owner_d = gidx;
            end
        end else if (state_q == ARB_LOCKED) begin
            wdog_d = wdog_q + 1'b1;
            if (wdog_d == WDOG_LIMIT) begin
                state_d    = ARB_IDLE;
                lock_err_d = 1'b1;
                wdog_d     = '0;
            end
        end
    end

    // State registers; reset drops any lock and kills an in-flight response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            owner_q     <= '0;
            ptr_q       <= '0;
            wdog_q      <= '0;
            rsp_valid_q <= '0;
            lock_err_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            wdog_q      <= wdog_d;
            rsp_valid_q <= rsp_valid_d;
            lock_err_q  <= lock_err_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign req_ready_o = grant;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = mem_rdata_i;
    assign lock_err_o  = lock_err_q;

endmodule
